hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-load-use hazard check in the ID stage.
- Keeps a per-register down-counter of cycles until a pending producer's result can be forwarded, for up to four latency classes (ALU, load, multiply, divide).
- Stalls ID on RAW and WAW hazards, squashes on flush, and exports a stall-cycle performance counter.
- Sits between the ID stage and the ID/EX register, and drives the PC, IF/ID and bubble controls.

Parameters:
- NREGS, 32: architectural registers; register 0 is never tracked.
- AW, 5: register address width (clog2 of NREGS).
- CW, 3: per-register counter width; every LATn must be at most 2^CW-1.
- LAT0, 0: forwarding delay of class 0 (ALU), in bubble cycles.
- LAT1, 1: class 1 (load).
- LAT2, 2: class 2 (multiply).
- LAT3, 4: class 3 (divide).
- PW, 32: width of the performance counter.

Ports:
- clk  in  1  clock, rising edge
- arst  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- rs1  in  AW  source register 1
- rs1_used  in  1  instruction reads rs1
- rs2  in  AW  source register 2
- rs2_used  in  1  instruction reads rs2
- rd  in  AW  destination register
- reg_write  in  1  instruction writes rd
- lat_class  in  2  latency class of the instruction
- flush  in  1  ID instruction is squashed this cycle (branch/jump taken)
- perf_clr  in  1  synchronous clear of stall_count
- stall  out  1  insert bubble into ID/EX (zero control)
- pc_write  out  1  PC enable, equals ~stall
- if_id_write  out  1  IF/ID enable, equals ~stall
- busy_vec  out  NREGS  bit r = (cnt[r] != 0)
- stall_count  out  PW  saturating count of stalled cycles

Behaviour:
- Reset is asynchronous and active-high. Every cnt[r] clears to 0 and stall_count clears to 0. As a result stall=0, pc_write=1, if_id_write=1 and busy_vec=0 while arst is asserted. Reset mid-operation drops all pending entries immediately.
- Hazard terms (combinational, zero-latency):
  - raw1 = rs1_used & rs1!=0 & cnt[rs1]!=0; raw2 is the same for rs2.
  - waw = reg_write & rd!=0 & cnt[rd] > LAT[lat_class].
- stall = id_valid & ~flush & (raw1 | raw2 | waw). flush has priority, so a squashed instruction never stalls.
- issue = id_valid & ~flush & ~stall.
- Counter update each rising edge, for every r:
  - If issue & reg_write & rd==r & r!=0: cnt[r] <= LAT[lat_class]. The set takes precedence over the decrement.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Else cnt[r] holds at 0.
- cnt[0] is constant 0. A class with LAT=0 writes 0, so nothing is tracked.
- Timing: a producer issuing in cycle t with latency L sets cnt=L at edge t+1. A dependent instruction in ID then stalls during cycles t+1 .. t+L and issues in cycle t+L+1, giving exactly L bubbles. Example: load-use gives 1 bubble, divide-use gives 4.
- A stalled instruction reevaluates every cycle. No state depends on the stall itself, other than the natural decrement.
- rs1==rs2 is evaluated identically (no double counting). rd==rs of the same instruction reads the old cnt, which is correct for in-order issue.
- stall_count:
  - perf_clr gives 0 (priority over increment).
  - Else stall gives +1, saturating at 2^PW-1.
  - Else it holds.
- Outputs pc_write and if_id_write are purely the inverse of stall. There are no registered outputs other than busy_vec and stall_count, which are derived from state.

Test Plan:
1. Reset: assert arst mid-run with cnt[5]=3 -> busy_vec=0, stall=0, pc_write=1, stall_count=0 asynchronously. Release, then an instruction reading x5 issues without stall.
2. Load-use: issue load rd=5 class1, then next instruction rs1=5 used -> stall=1 for exactly 1 cycle, stall_count=1, issue in the following cycle. Repeat with rs2=5 and the same result. With rs1_used=0 -> no stall.
3. Divide chain: issue class3 rd=7, then a consumer of x7 -> 4 stall cycles, pc_write=0 and if_id_write=0 in each. busy_vec[7] falls on the cycle the consumer issues.
4. WAW: issue class3 rd=9, then an ALU (class0) writing x9 -> stall until cnt[9] reaches 0 (4 cycles). Writer class3 writing x9 while cnt[9]=2 -> no stall, cnt[9] reloaded to 4.
5. Flush/x0: load rd=3, then a consumer of x3 with flush=1 -> stall=0 and no set. Load with rd=0, then a consumer of x0 -> no stall, busy_vec[0]=0.
6. Counter: hold a hazard for 2^PW+2 cycles at PW=4 -> saturates at 15. Assert perf_clr together with stall -> 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register forwarding-delay counters that
// stall ID on RAW/WAW hazards, with a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 3,
  parameter int LAT0  = 0,
  parameter int LAT1  = 1,
  parameter int LAT2  = 2,
  parameter int LAT3  = 4,
  parameter int PW    = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             id_valid,
  input  logic [AW-1:0]    rs1,
  input  logic             rs1_used,
  input  logic [AW-1:0]    rs2,
  input  logic             rs2_used,
  input  logic [AW-1:0]    rd,
  input  logic             reg_write,
  input  logic [1:0]       lat_class,
  input  logic             flush,
  input  logic             perf_clr,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [NREGS-1:0] busy_vec,
  output logic [PW-1:0]    stall_count
);

  logic [CW-1:0] cnt [NREGS];
  logic [CW-1:0] lat_sel;
  logic          raw1, raw2, waw, issue;

  always_comb begin
    lat_sel = '0;
    case (lat_class)
      2'd0:    lat_sel = CW'(LAT0);
      2'd1:    lat_sel = CW'(LAT1);
      2'd2:    lat_sel = CW'(LAT2);
      default: lat_sel = CW'(LAT3);
    endcase
  end

  // rd==rs of the same instruction sees the old count; the set lands next edge.
  always_comb begin
    raw1        = rs1_used  && (rs1 != '0) && (cnt[rs1] != '0);
    raw2        = rs2_used  && (rs2 != '0) && (cnt[rs2] != '0);
    waw         = reg_write && (rd  != '0) && (cnt[rd] > lat_sel);
    stall       = id_valid && !flush && (raw1 || raw2 || waw);
    issue       = id_valid && !flush && !stall;
    pc_write    = !stall;
    if_id_write = !stall;
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 0; r < NREGS; r++)
      busy_vec[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (issue && reg_write && (rd == AW'(r)))
          cnt[r] <= lat_sel;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      stall_count <= '0;
    else if (perf_clr)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + PW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, divide-use, WAW, flush,
// x0 handling, reset and stall-counter saturation with a 4-bit counter.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             id_valid;
  logic [AW-1:0]    rs1, rs2, rd;
  logic             rs1_used, rs2_used, reg_write, flush, perf_clr;
  logic [1:0]       lat_class;
  logic             stall, pc_write, if_id_write;
  logic [NREGS-1:0] busy_vec;
  logic [PW-1:0]    stall_count;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .NREGS(NREGS), .AW(AW), .CW(3),
    .LAT0(0), .LAT1(1), .LAT2(2), .LAT3(4), .PW(PW)
  ) dut (
    .clk(clk), .arst(arst), .id_valid(id_valid),
    .rs1(rs1), .rs1_used(rs1_used), .rs2(rs2), .rs2_used(rs2_used),
    .rd(rd), .reg_write(reg_write), .lat_class(lat_class),
    .flush(flush), .perf_clr(perf_clr),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .busy_vec(busy_vec), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [AW-1:0] a1, input logic u1,
                     input logic [AW-1:0] a2, input logic u2,
                     input logic [AW-1:0] d, input logic w,
                     input logic [1:0] c, input logic f);
    id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; reg_write = w; lat_class = c; flush = f;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_perf();
    idle();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
  endtask

  // Producer of class 3 into r, then a consumer of r: four bubbles.
  task automatic div_round(input logic [AW-1:0] r);
    drv(1'b1, '0, 1'b0, '0, 1'b0, r, 1'b1, 2'd3, 1'b0);
    tick();
    drv(1'b1, r, 1'b1, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
    repeat (4) tick();
    chk("div_round_issue", {31'd0, stall}, 32'd0);
    tick();
  endtask

  initial begin
    arst = 1'b1; perf_clr = 1'b0;
    idle();
    #12;
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pcw", {31'd0, pc_write}, 32'd1);
    chk("rst_ifid", {31'd0, if_id_write}, 32'd1);
    chk("rst_sc", {28'd0, stall_count}, 32'd0);
    arst = 1'b0;
    tick();

    // Test 1: reset mid-run with cnt[5]=3, consumer then issues freely.
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 2'd3, 1'b0);
    tick();                       // cnt5=4
    idle();
    tick();                       // cnt5=3
    drv(1'b1, 5'd5, 1'b1, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
    chk("t1_pre_stall", {31'd0, stall}, 32'd1);
    tick();                       // cnt5=2, sc=1
    chk("t1_pre_sc", {28'd0, stall_count}, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("t1_arst_busy", busy_vec, 32'd0);
    chk("t1_arst_stall", {31'd0, stall}, 32'd0);
    chk("t1_arst_pcw", {31'd0, pc_write}, 32'd1);
    chk("t1_arst_sc", {28'd0, stall_count}, 32'd0);
    arst = 1'b0;
    #1;
    chk("t1_post_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t1_post_busy", busy_vec, 32'd0);

    // Test 2: load-use via rs1, then rs2, then unused rs1.
    clr_perf();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
    tick();
    drv(1'b1, 5'd5, 1'b1, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
    chk("t2_rs1_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t2_rs1_go", {31'd0, stall}, 32'd0);
    chk("t2_rs1_sc", {28'd0, stall_count}, 32'd1);
    tick();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
    tick();
    drv(1'b1, '0, 1'b0, 5'd5, 1'b1, '0, 1'b0, 2'd0, 1'b0);
    chk("t2_rs2_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t2_rs2_go", {31'd0, stall}, 32'd0);
    chk("t2_rs2_sc", {28'd0, stall_count}, 32'd2);
    tick();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
    tick();
    drv(1'b1, 5'd5, 1'b0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
    chk("t2_unused", {31'd0, stall}, 32'd0);
    chk("t2_unused_busy", {31'd0, busy_vec[5]}, 32'd1);
    tick();

    // Test 3: divide-use, four bubbles with PC and IF/ID frozen.
    clr_perf();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 2'd3, 1'b0);
    tick();
    drv(1'b1, '0, 1'b0, 5'd7, 1'b1, '0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall", {31'd0, stall}, 32'd1);
      chk("t3_pcw", {31'd0, pc_write}, 32'd0);
      chk("t3_ifid", {31'd0, if_id_write}, 32'd0);
      chk("t3_busy7", {31'd0, busy_vec[7]}, 32'd1);
      tick();
    end
    chk("t3_go", {31'd0, stall}, 32'd0);
    chk("t3_busy7_fall", {31'd0, busy_vec[7]}, 32'd0);
    chk("t3_sc", {28'd0, stall_count}, 32'd4);
    tick();

    // Test 4: WAW behind a divide, then a reload with a longer writer.
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 2'd3, 1'b0);
    tick();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_waw_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    chk("t4_waw_go", {31'd0, stall}, 32'd0);
    tick();
    chk("t4_alu_untracked", {31'd0, busy_vec[9]}, 32'd0);
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 2'd3, 1'b0);
    tick();
    idle();
    repeat (2) tick();            // cnt9=2
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 2'd3, 1'b0);
    chk("t4_reload_nostall", {31'd0, stall}, 32'd0);
    tick();                       // cnt9=4
    idle();
    repeat (3) tick();
    chk("t4_reload_busy", {31'd0, busy_vec[9]}, 32'd1);
    tick();
    chk("t4_reload_done", {31'd0, busy_vec[9]}, 32'd0);

    // Test 5: flushed consumer neither stalls nor sets; x0 is never tracked.
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
    tick();
    drv(1'b1, 5'd3, 1'b1, '0, 1'b0, 5'd4, 1'b1, 2'd3, 1'b1);
    chk("t5_flush_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t5_flush_noset", {31'd0, busy_vec[4]}, 32'd0);
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0);
    tick();
    chk("t5_x0_busy", busy_vec, 32'd0);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, '0, 1'b0, 2'd0, 1'b0);
    chk("t5_x0_stall", {31'd0, stall}, 32'd0);
    tick();

    // Test 6: stall counter saturation and clear-while-stalling.
    clr_perf();
    for (int i = 0; i < 3; i++) div_round(5'd10);
    chk("t6_sc12", {28'd0, stall_count}, 32'd12);
    for (int i = 0; i < 2; i++) div_round(5'd10);
    chk("t6_sat", {28'd0, stall_count}, 32'd15);
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd11, 1'b1, 2'd3, 1'b0);
    tick();
    drv(1'b1, 5'd11, 1'b1, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0);
    perf_clr = 1'b1;
    chk("t6_clr_stall", {31'd0, stall}, 32'd1);
    tick();
    perf_clr = 1'b0;
    chk("t6_clr", {28'd0, stall_count}, 32'd0);
    tick();
    chk("t6_after_clr", {28'd0, stall_count}, 32'd1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
